// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame timing from syncs, locks onto
// the expected mode and emits pixel coordinates while locked.
module vga_timing_rx #(
  parameter int P_H_ACTIVE    = 1600,
  parameter int P_V_ACTIVE    = 900,
  parameter int P_H_TOTAL     = 1800,
  parameter int P_V_TOTAL     = 1000,
  parameter int P_LOCK_FRAMES = 2,
  parameter int P_WDOG        = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_H_sync,
  input  logic        i_V_sync,
  input  logic        i_RGB_valid,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic [23:0] o_pix,
  output logic        o_pix_valid,
  output logic [10:0] o_h_total,
  output logic [10:0] o_h_active,
  output logic [9:0]  o_v_total,
  output logic [9:0]  o_v_active,
  output logic        o_locked,
  output logic        o_err,
  output logic [31:0] o_frame_counter
);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_CHECK,
    S_LOCKED
  } state_t;

  localparam logic [10:0] LP_HA   = 11'(P_H_ACTIVE);
  localparam logic [11:0] LP_HT   = 12'(P_H_TOTAL);
  localparam logic [9:0]  LP_VA   = 10'(P_V_ACTIVE);
  localparam logic [9:0]  LP_VT   = 10'(P_V_TOTAL);
  localparam logic [7:0]  LP_LOCK = 8'(P_LOCK_FRAMES);
  localparam logic [11:0] LP_WDOG = 12'(P_WDOG);

  logic        h_prev_q, h_prev_d, v_prev_q, v_prev_d;
  logic [11:0] lclk_q, lclk_d;
  logic [10:0] pcnt_q, pcnt_d, pbase;
  logic [9:0]  line_q, line_d, line_h;
  logic [9:0]  aline_q, aline_d, aline_h;
  logic [10:0] h_total_q, h_total_d;
  logic [10:0] h_active_q, h_active_d;
  logic [9:0]  v_total_q, v_total_d;
  logic [9:0]  v_active_q, v_active_d;
  logic        bad_q, bad_d, bad_h;
  state_t      state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [31:0] fc_q, fc_d;
  logic        err_q, err_d;
  logic        pv_q, pv_d;
  logic [23:0] rgb_q, rgb_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hf, vf, wdog, line_bad, frame_good;

  always_comb begin
    h_prev_d   = i_H_sync;
    v_prev_d   = i_V_sync;
    hf         = h_prev_q & ~i_H_sync;
    vf         = v_prev_q & ~i_V_sync;
    h_total_d  = h_total_q;
    h_active_d = h_active_q;
    v_total_d  = v_total_q;
    v_active_d = v_active_q;
    line_h     = line_q;
    aline_h    = aline_q;
    bad_h      = bad_q;

    if (hf) lclk_d = 12'd1;
    else if (lclk_q == 12'hfff) lclk_d = lclk_q;
    else lclk_d = lclk_q + 12'd1;

    pbase  = hf ? 11'd0 : pcnt_q;
    pcnt_d = pbase + 11'(i_RGB_valid);

    line_bad = (pcnt_q != '0 && pcnt_q != LP_HA)
             || lclk_q != LP_HT;
    if (hf) begin
      line_h    = line_q + 10'd1;
      h_total_d = lclk_q[10:0];
      if (pcnt_q != '0) begin
        aline_h    = aline_q + 10'd1;
        h_active_d = pcnt_q;
      end
      if (line_bad) bad_h = 1'b1;
    end

    // Frame verdict uses counts that already include a same-cycle HF.
    frame_good = !bad_h && line_h == LP_VT
               && aline_h == LP_VA;
    line_d  = line_h;
    aline_d = aline_h;
    bad_d   = bad_h;
    if (vf) begin
      v_total_d  = line_h;
      v_active_d = aline_h;
      line_d     = '0;
      aline_d    = '0;
      bad_d      = 1'b0;
    end

    pv_d  = i_RGB_valid;
    rgb_d = i_RGB_valid ? {i_R, i_G, i_B} : 24'd0;
    x_d   = pbase;
    y_d   = aline_d;
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    fc_d    = fc_q;
    err_d   = 1'b0;
    wdog    = !hf && lclk_q >= LP_WDOG;
    if (wdog) begin
      state_d = S_SEARCH;
      err_d   = state_q == S_LOCKED;
    end else if (vf) begin
      unique case (state_q)
        S_SEARCH: begin
          state_d = S_CHECK;
          good_d  = '0;
        end
        S_CHECK: begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= LP_LOCK)
              state_d = S_LOCKED;
          end else begin
            good_d = '0;
          end
        end
        S_LOCKED: begin
          if (frame_good) begin
            fc_d = fc_q + 32'd1;
          end else begin
            state_d = S_SEARCH;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_prev_q   <= 1'b1;
      v_prev_q   <= 1'b1;
      lclk_q     <= '0;
      pcnt_q     <= '0;
      line_q     <= '0;
      aline_q    <= '0;
      h_total_q  <= '0;
      h_active_q <= '0;
      v_total_q  <= '0;
      v_active_q <= '0;
      bad_q      <= 1'b0;
      state_q    <= S_SEARCH;
      good_q     <= '0;
      fc_q       <= '0;
      err_q      <= 1'b0;
      pv_q       <= 1'b0;
      rgb_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      h_prev_q   <= h_prev_d;
      v_prev_q   <= v_prev_d;
      lclk_q     <= lclk_d;
      pcnt_q     <= pcnt_d;
      line_q     <= line_d;
      aline_q    <= aline_d;
      h_total_q  <= h_total_d;
      h_active_q <= h_active_d;
      v_total_q  <= v_total_d;
      v_active_q <= v_active_d;
      bad_q      <= bad_d;
      state_q    <= state_d;
      good_q     <= good_d;
      fc_q       <= fc_d;
      err_q      <= err_d;
      pv_q       <= pv_d;
      rgb_q      <= rgb_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign o_locked        = state_q == S_LOCKED;
  assign o_pix_valid     = pv_q & o_locked;
  assign o_pix           = o_pix_valid ? rgb_q : 24'd0;
  assign o_x             = x_q;
  assign o_y             = y_q;
  assign o_h_total       = h_total_q;
  assign o_h_active      = h_active_q;
  assign o_v_total       = v_total_q;
  assign o_v_active      = v_active_q;
  assign o_err           = err_q;
  assign o_frame_counter = fc_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx using a scaled-down 16x9 mode
// (24 clk/line, 12 lines/frame) so every scenario fits a short run.
module tb_vga_timing_rx;
  localparam int HA = 16;
  localparam int VA = 9;
  localparam int HT = 24;
  localparam int VT = 12;
  localparam int LK = 2;
  localparam int WD = 100;
  localparam int PX0 = 4;

  logic        clk = 1'b0;
  logic        rst_n, h_sync, v_sync, rgb_valid;
  logic [7:0]  r, g, b;
  logic [10:0] o_x;
  logic [9:0]  o_y;
  logic [23:0] o_pix;
  logic        o_pix_valid;
  logic [10:0] o_h_total, o_h_active;
  logic [9:0]  o_v_total, o_v_active;
  logic        o_locked, o_err;
  logic [31:0] o_frame_counter;

  always #5 clk = ~clk;

  vga_timing_rx #(
    .P_H_ACTIVE(HA), .P_V_ACTIVE(VA),
    .P_H_TOTAL(HT), .P_V_TOTAL(VT),
    .P_LOCK_FRAMES(LK), .P_WDOG(WD)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_H_sync(h_sync), .i_V_sync(v_sync),
    .i_RGB_valid(rgb_valid),
    .i_R(r), .i_G(g), .i_B(b),
    .o_x(o_x), .o_y(o_y), .o_pix(o_pix),
    .o_pix_valid(o_pix_valid),
    .o_h_total(o_h_total), .o_h_active(o_h_active),
    .o_v_total(o_v_total), .o_v_active(o_v_active),
    .o_locked(o_locked), .o_err(o_err),
    .o_frame_counter(o_frame_counter)
  );

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [23:0] pix;
  } pix_t;

  typedef struct {
    logic        lk;
    logic        err;
    logic [31:0] fc;
    bit          meas;
  } ev_t;

  pix_t pq[$];
  ev_t  eq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_seen = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 32'(o_locked), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_fc"}, o_frame_counter, 0);
    chk({tag, "_htot"}, 32'(o_h_total), 0);
    chk({tag, "_hact"}, 32'(o_h_active), 0);
    chk({tag, "_vtot"}, 32'(o_v_total), 0);
    chk({tag, "_vact"}, 32'(o_v_active), 0);
    chk({tag, "_pv"}, 32'(o_pix_valid), 0);
    chk({tag, "_pix"}, 32'(o_pix), 0);
    chk({tag, "_x"}, 32'(o_x), 0);
    chk({tag, "_y"}, 32'(o_y), 0);
  endtask

  // Monitor: pops expectations when the DUT shows a pixel or a frame edge.
  initial begin : mon
    logic vprev;
    logic vf;
    pix_t p;
    ev_t  e;
    vprev = 1'b1;
    forever begin
      @(posedge clk);
      vf = 1'b0;
      if (!rst_n) begin
        vprev = 1'b1;
      end else begin
        vf    = vprev & ~v_sync;
        vprev = v_sync;
      end
      #3;
      if (o_err) err_seen++;
      if (o_pix_valid) begin
        if (pq.size() == 0) begin
          chk("pix_valid_unexp", 32'(o_pix_valid), 0);
        end else begin
          p = pq.pop_front();
          chk("pix_x", 32'(o_x), 32'(p.x));
          chk("pix_y", 32'(o_y), 32'(p.y));
          chk("pix_rgb", 32'(o_pix), 32'(p.pix));
        end
      end
      if (vf) begin
        if (eq.size() == 0) begin
          chk("vf_unexp", 32'(vf), 0);
        end else begin
          e = eq.pop_front();
          chk("vf_locked", 32'(o_locked), 32'(e.lk));
          chk("vf_err", 32'(o_err), 32'(e.err));
          chk("vf_fc", o_frame_counter, e.fc);
          if (e.meas) begin
            chk("vf_htot", 32'(o_h_total), HT);
            chk("vf_hact", 32'(o_h_active), HA);
            chk("vf_vtot", 32'(o_v_total), VT);
            chk("vf_vact", 32'(o_v_active), VA);
          end
        end
      end
    end
  end

  task automatic drive_frame(input int short_ln,
                             input bit push,
                             input logic elk,
                             input logic eerr,
                             input logic [31:0] efc,
                             input bit meas,
                             input int rst_ln,
                             input bit frc,
                             input logic [7:0] fid);
    bit lk;
    logic val;
    logic [23:0] px;
    lk = push;
    for (int ln = 0; ln < VT; ln++) begin
      for (int c = 0; c < HT; c++) begin
        @(posedge clk);
        #1;
        if (ln == 0 && c == 0)
          eq.push_back('{elk, eerr, efc, meas});
        if (ln == rst_ln && c == 23) begin
          lk = 1'b0;
          chk_zero("midrst");
        end
        rst_n  = !(ln == rst_ln && c == 22);
        h_sync = c >= 2;
        v_sync = ln >= 2;
        val = ln < VA && c >= PX0 && c < PX0 + HA
            && !(ln == short_ln && c == PX0 + HA - 1);
        if (!val) px = 24'd0;
        else if (ln == 0 && c == PX0) px = 24'h123456;
        else px = {fid, 8'(ln), 8'(c)};
        rgb_valid = val;
        {r, g, b} = px;
        if (val && lk)
          pq.push_back('{11'(c - PX0), 10'(ln), px});
        if (frc && ln == 6 && c == 0)
          force dut.fc_q = 32'hffff_ffff;
        if (frc && ln == 6 && c == 2)
          release dut.fc_q;
      end
    end
  endtask

  initial begin : stim
    int wd_at;
    rst_n = 1'b0;
    h_sync = 1'b1;
    v_sync = 1'b1;
    rgb_valid = 1'b0;
    {r, g, b} = 24'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // Acquire lock: SEARCH -> CHECK -> good -> LOCKED at third VF.
    drive_frame(-1, 0, 0, 0, 0, 0, -1, 0, 8'd1);
    drive_frame(-1, 0, 0, 0, 0, 1, -1, 0, 8'd2);
    drive_frame(-1, 1, 1, 0, 0, 1, -1, 0, 8'd3);
    drive_frame(-1, 1, 1, 0, 1, 1, -1, 0, 8'd4);
    // One short line, lock lost at the following VF.
    drive_frame(3, 1, 1, 0, 2, 1, -1, 0, 8'd5);
    drive_frame(-1, 0, 0, 1, 2, 1, -1, 0, 8'd6);
    drive_frame(-1, 0, 0, 0, 2, 1, -1, 0, 8'd7);
    drive_frame(-1, 0, 0, 0, 2, 1, -1, 0, 8'd8);
    drive_frame(-1, 1, 1, 0, 2, 1, -1, 0, 8'd9);
    drive_frame(-1, 1, 1, 0, 3, 1, -1, 0, 8'd10);

    // Syncs stuck high: watchdog drops lock WD clocks after last HF.
    wd_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      h_sync = 1'b1;
      v_sync = 1'b1;
      rgb_valid = 1'b0;
      {r, g, b} = 24'd0;
      if (!o_locked && wd_at < 0) begin
        wd_at = i;
        chk("wdog_err", 32'(o_err), 1);
      end
    end
    chk("wdog_cycle", 32'(wd_at), WD - (HT - 1));
    chk("wdog_htot_hold", 32'(o_h_total), HT);
    chk("wdog_vtot_hold", 32'(o_v_total), VT);
    chk("wdog_fc_hold", o_frame_counter, 3);
    chk("err_pulses_a", 32'(err_seen), 2);

    drive_frame(-1, 0, 0, 0, 3, 0, -1, 0, 8'd11);
    drive_frame(-1, 0, 0, 0, 3, 1, -1, 0, 8'd12);
    // Locked, then a one-clock reset mid-frame.
    drive_frame(-1, 1, 1, 0, 3, 1, 5, 0, 8'd13);
    drive_frame(-1, 0, 0, 0, 0, 0, -1, 0, 8'd14);
    drive_frame(-1, 0, 0, 0, 0, 1, -1, 0, 8'd15);
    drive_frame(-1, 1, 1, 0, 0, 1, -1, 0, 8'd16);
    // Counter preset to all-ones, next good frame wraps it.
    drive_frame(-1, 1, 1, 0, 1, 1, -1, 1, 8'd17);
    drive_frame(-1, 1, 1, 0, 0, 1, -1, 0, 8'd18);

    repeat (4) @(posedge clk);
    #4;
    chk("pix_left", 32'(pq.size()), 0);
    chk("ev_left", 32'(eq.size()), 0);
    chk("err_pulses_b", 32'(err_seen), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
